// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl_pkg
//  Brief    : Shared constants, ALU opcode encoding and controller states
//             for the ALU issue/writeback controller.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_issue_ctrl_pkg;

    localparam int c_WIDTH = 4;
    localparam int c_NREGS = 4;

    // ALU opcode encoding, shared with the combinational alu
    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SLL = 3'b101;
    localparam logic [2:0] c_OP_SRL = 3'b110;
    localparam logic [2:0] c_OP_NOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl_if
//  Brief    : Bundle of the instruction handshake, direct-load port, alu
//             drive/return, flag, done and debug-read signals.
//             slave  = the controller, master = the upstream/alu side.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int AW    = 2
);
    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       instr_op;
    logic [AW-1:0]    instr_rd;
    logic [AW-1:0]    instr_rs1;
    logic [AW-1:0]    instr_rs2;
    logic             ld_en;
    logic [AW-1:0]    ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_carry;
    logic             flag_zero;
    logic             flag_carry;
    logic             done;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        input  ld_en, ld_addr, ld_data,
        input  alu_result, alu_zero, alu_carry,
        input  dbg_addr,
        output instr_ready, alu_a, alu_b, alu_op,
        output flag_zero, flag_carry, done, dbg_data
    );

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        output ld_en, ld_addr, ld_data,
        output alu_result, alu_zero, alu_carry,
        output dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_op,
        input  flag_zero, flag_carry, done, dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl_regfile
//  Brief    : NREGS x WIDTH register file, two combinational issue read
//             ports plus a debug read port, writeback and direct-load write
//             ports. Writeback wins over load on the same address.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl_regfile
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int NREGS = c_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [AW-1:0]    i_rd_addr_a,
    input  wire logic [AW-1:0]    i_rd_addr_b,
    output logic      [WIDTH-1:0] o_rd_data_a,
    output logic      [WIDTH-1:0] o_rd_data_b,
    input  wire logic [AW-1:0]    i_dbg_addr,
    output logic      [WIDTH-1:0] o_dbg_data,
    input  wire logic             i_wb_en,
    input  wire logic [AW-1:0]    i_wb_addr,
    input  wire logic [WIDTH-1:0] i_wb_data,
    input  wire logic             i_ld_en,
    input  wire logic [AW-1:0]    i_ld_addr,
    input  wire logic [WIDTH-1:0] i_ld_data
);

    logic [WIDTH-1:0] r_mem [NREGS];

    // Storage update: writeback checked first so it overrides a same-address load
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (i_wb_en && (i_wb_addr == AW'(i))) begin
                    r_mem[i] <= i_wb_data;
                end else if (i_ld_en && (i_ld_addr == AW'(i))) begin
                    r_mem[i] <= i_ld_data;
                end
            end
        end
    end

    assign o_rd_data_a = r_mem[i_rd_addr_a];
    assign o_rd_data_b = r_mem[i_rd_addr_b];
    assign o_dbg_data  = r_mem[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl
//  Brief    : Issue/writeback controller for the combinational alu.
//             IDLE accepts an instruction and latches operands, EXEC lets
//             the alu settle and captures its outputs, WB writes the result
//             back, updates the sticky flags and pulses done.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int NREGS = c_NREGS
) (
    input wire logic        clk,
    input wire logic        rst,
    alu_issue_ctrl_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    state_t           r_state;
    logic [AW-1:0]    r_rd;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_op;
    logic             r_flag_zero;
    logic             r_flag_carry;
    logic             r_done;

    logic [WIDTH-1:0] w_rs1_data;
    logic [WIDTH-1:0] w_rs2_data;
    logic             w_wb_en;

    assign w_wb_en = (r_state == ST_WB);

    alu_issue_ctrl_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_rd_addr_a (bus.instr_rs1),
        .i_rd_addr_b (bus.instr_rs2),
        .o_rd_data_a (w_rs1_data),
        .o_rd_data_b (w_rs2_data),
        .i_dbg_addr  (bus.dbg_addr),
        .o_dbg_data  (bus.dbg_data),
        .i_wb_en     (w_wb_en),
        .i_wb_addr   (r_rd),
        .i_wb_data   (r_result),
        .i_ld_en     (bus.ld_en),
        .i_ld_addr   (bus.ld_addr),
        .i_ld_data   (bus.ld_data)
    );

    // Issue FSM with operand, result and flag latches; reset abandons any op in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rd         <= '0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_carry      <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_flag_zero  <= 1'b0;
            r_flag_carry <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        r_alu_a  <= w_rs1_data;
                        r_alu_b  <= w_rs2_data;
                        r_alu_op <= bus.instr_op;
                        r_rd     <= bus.instr_rd;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result <= bus.alu_result;
                    r_zero   <= bus.alu_zero;
                    r_carry  <= bus.alu_carry;
                    r_done   <= 1'b1;
                    r_state  <= ST_WB;
                end
                ST_WB: begin
                    r_flag_zero  <= r_zero;
                    r_flag_carry <= r_carry;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready = (r_state == ST_IDLE) && !rst;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_op      = r_alu_op;
    assign bus.flag_zero   = r_flag_zero;
    assign bus.flag_carry  = r_flag_carry;
    assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_ctrl
//  Brief    : Directed self-checking bench for alu_issue_ctrl with a
//             behavioural 4-bit alu closing the loop.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_issue_ctrl_if #(.WIDTH(4), .AW(2)) bus ();

    alu_issue_ctrl #(.WIDTH(4), .NREGS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural alu: carry is carry-out for ADD, borrow for SUB, 0 otherwise
    logic [4:0] w_sum;
    logic [3:0] w_res;
    logic       w_cy;
    always_comb begin
        w_sum = '0;
        w_res = '0;
        w_cy  = 1'b0;
        case (bus.alu_op)
            c_OP_ADD: begin w_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}; w_res = w_sum[3:0]; w_cy = w_sum[4]; end
            c_OP_SUB: begin w_sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b}; w_res = w_sum[3:0]; w_cy = w_sum[4]; end
            c_OP_AND: w_res = bus.alu_a & bus.alu_b;
            c_OP_OR : w_res = bus.alu_a | bus.alu_b;
            c_OP_XOR: w_res = bus.alu_a ^ bus.alu_b;
            c_OP_SLL: w_res = bus.alu_a << bus.alu_b[1:0];
            c_OP_SRL: w_res = bus.alu_a >> bus.alu_b[1:0];
            default : w_res = ~(bus.alu_a | bus.alu_b);
        endcase
    end
    assign bus.alu_result = w_res;
    assign bus.alu_zero   = (w_res == 4'd0);
    assign bus.alu_carry  = w_cy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_check(input string tag, input logic [1:0] addr, input logic [3:0] exp);
        bus.dbg_addr = addr;
        #1;
        check(tag, 32'(bus.dbg_data), 32'(exp));
    endtask

    task automatic flags_check(input string tag, input logic z, input logic c);
        check({tag, "_zero"},  32'(bus.flag_zero),  32'(z));
        check({tag, "_carry"}, 32'(bus.flag_carry), 32'(c));
    endtask

    task automatic load(input logic [1:0] addr, input logic [3:0] data);
        bus.ld_en   = 1'b1;
        bus.ld_addr = addr;
        bus.ld_data = data;
        tick();
        bus.ld_en   = 1'b0;
    endtask

    // Full issue: checks operand drive, done timing and optionally loads at the WB edge
    task automatic issue(input string tag, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic [3:0] exp_a, input logic [3:0] exp_b,
                         input bit wb_ld, input logic [1:0] la, input logic [3:0] ldat);
        int n_wait;
        n_wait = 0;
        while (!bus.instr_ready && n_wait < 20) begin
            tick();
            n_wait++;
        end
        check({tag, "_ready"}, 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_rs1   = rs1;
        bus.instr_rs2   = rs2;
        tick();
        bus.instr_valid = 1'b0;
        check({tag, "_alu_a"}, 32'(bus.alu_a), 32'(exp_a));
        check({tag, "_alu_b"}, 32'(bus.alu_b), 32'(exp_b));
        check({tag, "_alu_op"}, 32'(bus.alu_op), 32'(op));
        check({tag, "_done_exec"}, 32'(bus.done), 32'd0);
        tick();
        check({tag, "_done_wb"}, 32'(bus.done), 32'd1);
        if (wb_ld) begin
            bus.ld_en   = 1'b1;
            bus.ld_addr = la;
            bus.ld_data = ldat;
        end
        tick();
        bus.ld_en = 1'b0;
        check({tag, "_done_after"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] done_pat;
        int         n_done;
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_op    = '0;
        bus.instr_rd    = '0;
        bus.instr_rs1   = '0;
        bus.instr_rs2   = '0;
        bus.ld_en       = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.dbg_addr    = '0;

        // Reset state
        tick();
        tick();
        check("rst_ready", 32'(bus.instr_ready), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_alu_a", 32'(bus.alu_a), 32'd0);
        flags_check("rst", 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", 32'(bus.instr_ready), 32'd1);
        for (int i = 0; i < 4; i++) rf_check("rst_rf", 2'(i), 4'h0);

        // 1: ADD 5+3 -> 8
        load(2'd0, 4'b0101);
        load(2'd1, 4'b0011);
        issue("t1", c_OP_ADD, 2'd2, 2'd0, 2'd1, 4'b0101, 4'b0011, 1'b0, 2'd0, 4'd0);
        rf_check("t1_rf2", 2'd2, 4'b1000);
        flags_check("t1", 1'b0, 1'b0);

        // 2: SUB r0-r0 -> 0, zero
        issue("t2", c_OP_SUB, 2'd3, 2'd0, 2'd0, 4'b0101, 4'b0101, 1'b0, 2'd0, 4'd0);
        rf_check("t2_rf3", 2'd3, 4'b0000);
        flags_check("t2", 1'b1, 1'b0);

        // 3: ADD F+1 -> 0 with carry, rd == rs1
        load(2'd0, 4'b1111);
        load(2'd1, 4'b0001);
        issue("t3", c_OP_ADD, 2'd0, 2'd0, 2'd1, 4'b1111, 4'b0001, 1'b0, 2'd0, 4'd0);
        rf_check("t3_rf0", 2'd0, 4'b0000);
        flags_check("t3", 1'b1, 1'b1);

        // Load leaves flags alone
        load(2'd3, 4'b0110);
        flags_check("ld_flags", 1'b1, 1'b1);
        rf_check("ld_rf3", 2'd3, 4'b0110);

        // 4: AND r1&r1 -> 1 with a same-address load at the WB edge
        issue("t4", c_OP_AND, 2'd2, 2'd1, 2'd1, 4'b0001, 4'b0001, 1'b1, 2'd2, 4'b1111);
        rf_check("t4_rf2", 2'd2, 4'b0001);
        flags_check("t4", 1'b0, 1'b0);

        // 5: NOR r0,r1 with valid held through the busy period
        bus.instr_valid = 1'b1;
        bus.instr_op    = c_OP_NOR;
        bus.instr_rd    = 2'd3;
        bus.instr_rs1   = 2'd0;
        bus.instr_rs2   = 2'd1;
        done_pat        = '0;
        n_done          = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            done_pat[i-1] = bus.done;
            if (bus.done) n_done++;
            if (i == 1) check("t5_busy_ready_exec", 32'(bus.instr_ready), 32'd0);
            if (i == 2) check("t5_busy_ready_wb", 32'(bus.instr_ready), 32'd0);
            if (i == 3) check("t5_ready_after_done", 32'(bus.instr_ready), 32'd1);
            if (i == 4) bus.instr_valid = 1'b0;
        end
        check("t5_done_pattern", 32'(done_pat), 32'h12);
        check("t5_done_count", 32'(n_done), 32'd2);
        rf_check("t5_rf3", 2'd3, 4'b1110);
        flags_check("t5", 1'b0, 1'b0);

        // 6: reset during EXEC after flags were set
        issue("t6a", c_OP_SUB, 2'd1, 2'd0, 2'd0, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0);
        flags_check("t6a", 1'b1, 1'b0);
        bus.instr_valid = 1'b1;
        bus.instr_op    = c_OP_ADD;
        bus.instr_rd    = 2'd2;
        bus.instr_rs1   = 2'd3;
        bus.instr_rs2   = 2'd3;
        tick();
        bus.instr_valid = 1'b0;
        check("t6_alu_a", 32'(bus.alu_a), 32'hE);
        rst = 1'b1;
        tick();
        check("t6_done", 32'(bus.done), 32'd0);
        check("t6_ready_in_rst", 32'(bus.instr_ready), 32'd0);
        flags_check("t6", 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("t6_ready_release", 32'(bus.instr_ready), 32'd1);
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.done) n_done++;
        end
        check("t6_no_done", 32'(n_done), 32'd0);
        rf_check("t6_rf2", 2'd2, 4'b0000);
        rf_check("t6_rf3", 2'd3, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
